// File: rtl/ifq_pkg.sv
// Shared constants and state type for the instruction fetch queue.
package ifq_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH,
        DRAIN
    } ifq_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Small circular FIFO with synchronous flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module ifq_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload storage needs no reset; count_q gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues in-order reads, buffers returned instructions
// with their PCs, and drains stale responses after a redirect. IFQ_ALIGN_CHECK_EN
// enables redirect-target alignment checking.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned     XLEN      = DEFAULT_XLEN,
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            mem_rdy,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            proc_req,
    output logic            we,
    output logic [XLEN-1:0] addr_out,
    input  logic            dec_ready,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            freeze,
    output logic            misalign
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    ifq_state_e      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            active_q;

    logic [CW-1:0]   count;
    logic            full, empty;
    logic [2*XLEN-1:0] head;
    logic [CW:0]     occupancy;
    logic            req_fire, resp_fire, push, pop;
    logic [XLEN-1:0] resp_pc, target_pc;

`ifdef IFQ_ALIGN_CHECK_EN
    logic misalign_q;

    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign = misalign_q;
`else
    assign target_pc = redirect_pc;
    assign misalign  = 1'b0;
`endif

    // Responses with nothing in flight are spurious and ignored.
    assign resp_fire = mem_valid && (outst_q != '0);
    assign occupancy = {1'b0, count} + {1'b0, outst_q};

    // Holds stable under mem_rdy=0: only pops, responses or a redirect can change it.
    assign proc_req = active_q && (state_q == FETCH) && (outst_q < CW'(MAX_OUTST)) &&
                      (occupancy < (CW + 1)'(DEPTH)) && !redirect;
    assign addr_out = fetch_pc_q;
    assign we       = 1'b0;
    assign req_fire = proc_req && mem_rdy;

    // In FETCH every in-flight read is live and sequential, so the oldest one sits
    // outst_q words behind fetch_pc.
    assign resp_pc = fetch_pc_q - (XLEN'(outst_q) << 2);
    assign push    = resp_fire && (state_q == FETCH) && !redirect && !full;
    assign pop     = !empty && dec_ready;

    ifq_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({mem_rdata, resp_pc}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign instr_valid = !empty;
    assign freeze      = empty;
    assign instr_out   = empty ? XLEN'(NOP) : head[2*XLEN-1:XLEN];
    assign pc_out      = empty ? '0 : head[XLEN-1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(resp_fire);
        discard_d  = discard_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        unique case (state_q)
            FETCH: begin
                state_d = FETCH;
            end
            DRAIN: begin
                if (resp_fire) begin
                    discard_d = discard_q - CW'(1);
                    if (discard_q == CW'(1)) begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = FETCH;
        endcase

        // A redirect overrides everything, including one already in progress.
        if (redirect) begin
            fetch_pc_d = target_pc;
            discard_d  = outst_q - CW'(resp_fire);
            state_d    = (discard_d != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            active_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MAX_OUTST = 3;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
`ifdef IFQ_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect, mem_rdy, mem_valid, dec_ready;
    logic [31:0] redirect_pc, mem_rdata;
    logic        proc_req, we, instr_valid, freeze, misalign;
    logic [31:0] addr_out, instr_out, pc_out;

    always #5 clk = ~clk;

    ifetch_queue #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_rdy     (mem_rdy),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .proc_req    (proc_req),
        .we          (we),
        .addr_out    (addr_out),
        .dec_ready   (dec_ready),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .freeze      (freeze),
        .misalign    (misalign)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: reads in flight (oldest first) and buffered instructions.
    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } req_t;

    req_t        m_out[$];
    logic [31:0] m_qpc[$];
    logic [31:0] m_qdat[$];
    logic [31:0] m_fetch;
    bit          m_mis;

    // Memory environment and logs of accepted addresses / enqueued PCs.
    logic [31:0] mem_addr[$];
    int          mem_due[$];
    logic [31:0] acc_log[$];
    logic [31:0] push_log[$];
    int          cyc = 0;

    int p_rdy, p_dec, p_redir, lat_min, lat_max;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pick_pc();
        case ($urandom_range(5))
            0: return 32'h0000_0100;
            1: return 32'h0000_0200;
            2: return 32'h0000_0102;
            3: return 32'hFFFF_FFF8;
            4: return $urandom & 32'h0000_0FFC;
            default: return $urandom & 32'h0000_0FFF;
        endcase
    endfunction

    task automatic idle_inputs();
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_rdy     = 1'b0;
        mem_valid   = 1'b0;
        mem_rdata   = '0;
        dec_ready   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        m_out.delete();
        m_qpc.delete();
        m_qdat.delete();
        mem_addr.delete();
        mem_due.delete();
        m_fetch = 32'h0000_0000;
        m_mis   = 1'b0;
        #1;
        check("rst_proc_req", proc_req, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_freeze", freeze, 1);
        check("rst_misalign", misalign, 0);
        check("rst_we", we, 0);
        check("rst_instr_out", instr_out, NOP_INSTR);
        check("rst_pc_out", pc_out, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input bit fr, input logic [31:0] fpc);
        bit          e_req, drain, resp, mem_resp, st;
        int          d;
        logic [31:0] rpc;
        @(negedge clk);
        cyc++;
        mem_rdy     = ($urandom_range(99) < p_rdy);
        dec_ready   = ($urandom_range(99) < p_dec);
        redirect    = fr || ($urandom_range(99) < p_redir);
        redirect_pc = fr ? fpc : pick_pc();
        mem_resp    = (mem_due.size() > 0) && (mem_due[0] <= cyc);
        if (mem_resp) begin
            mem_valid = 1'b1;
            mem_rdata = fdata(mem_addr[0]);
        end else begin
            mem_valid = (mem_due.size() == 0) && ($urandom_range(99) < 5);
            mem_rdata = $urandom;
        end
        #1;
        drain = 1'b0;
        foreach (m_out[i]) if (m_out[i].stale) drain = 1'b1;
        e_req = !drain && (m_out.size() < MAX_OUTST) &&
                ((m_qpc.size() + m_out.size()) < DEPTH) && !redirect;
        check("proc_req", proc_req, e_req);
        if (e_req) check("addr_out", addr_out, m_fetch);
        check("instr_valid", instr_valid, m_qpc.size() != 0);
        check("freeze", freeze, m_qpc.size() == 0);
        check("instr_out", instr_out, (m_qpc.size() != 0) ? m_qdat[0] : NOP_INSTR);
        check("pc_out", pc_out, (m_qpc.size() != 0) ? m_qpc[0] : 32'h0);
        check("we", we, 0);
        check("misalign", misalign, m_mis);

        // Memory side follows what the DUT actually presents.
        if (mem_resp) begin
            mem_addr.delete(0);
            mem_due.delete(0);
        end
        if (proc_req && mem_rdy) begin
            d = cyc + $urandom_range(lat_max, lat_min);
            if (mem_due.size() > 0 && d <= mem_due[$]) d = mem_due[$] + 1;
            acc_log.push_back(addr_out);
            mem_addr.push_back(addr_out);
            mem_due.push_back(d);
        end

        resp = mem_valid && (m_out.size() > 0);
        st   = 1'b1;
        rpc  = '0;
        if (resp) begin
            st  = m_out[0].stale;
            rpc = m_out[0].pc;
            m_out.delete(0);
        end
        if (redirect) begin
            m_qpc.delete();
            m_qdat.delete();
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            m_fetch = ALIGN ? {redirect_pc[31:2], 2'b00} : redirect_pc;
        end else begin
            if (dec_ready && m_qpc.size() > 0) begin
                m_qpc.delete(0);
                m_qdat.delete(0);
            end
            if (resp && !st) begin
                m_qpc.push_back(rpc);
                m_qdat.push_back(mem_rdata);
                push_log.push_back(rpc);
            end
        end
        if (e_req && mem_rdy) begin
            m_out.push_back('{pc: m_fetch, stale: 1'b0});
            m_fetch = m_fetch + 32'd4;
        end
        m_mis = ALIGN && redirect && (redirect_pc[1:0] != 2'b00);
    endtask

    initial begin
        idle_inputs();

        // Streaming fetch with a fixed two-cycle memory.
        do_reset();
        p_rdy = 100; p_dec = 100; p_redir = 0; lat_min = 2; lat_max = 2;
        acc_log.delete();
        push_log.delete();
        repeat (20) step(1'b0, '0);
        check("seq_addr0", at(acc_log, 0), 32'h0);
        check("seq_addr1", at(acc_log, 1), 32'h4);
        check("seq_addr2", at(acc_log, 2), 32'h8);
        check("seq_pc0", at(push_log, 0), 32'h0);

        // Decode stalled: occupancy caps accepted reads at DEPTH.
        do_reset();
        p_dec = 0; lat_min = 1; lat_max = 3;
        acc_log.delete();
        repeat (20) step(1'b0, '0);
        check("accepts_full", acc_log.size(), DEPTH);
        p_dec = 100;
        repeat (6) step(1'b0, '0);
        check("accepts_resume", acc_log.size() > DEPTH, 1);

        // Memory not ready: request held with an empty queue.
        do_reset();
        p_rdy = 0;
        repeat (3) step(1'b0, '0);
        p_rdy = 100;
        repeat (6) step(1'b0, '0);

        // Redirect with reads in flight, then redirect again while draining.
        do_reset();
        lat_min = 4; lat_max = 4;
        repeat (8) step(1'b0, '0);
        acc_log.delete();
        push_log.delete();
        step(1'b1, 32'h0000_0100);
        repeat (15) step(1'b0, '0);
        check("redir_addr", at(acc_log, 0), 32'h100);
        check("redir_pc", at(push_log, 0), 32'h100);
        step(1'b1, 32'h0000_0100);
        acc_log.delete();
        push_log.delete();
        step(1'b1, 32'h0000_0200);
        repeat (15) step(1'b0, '0);
        check("drain_redir_addr", at(acc_log, 0), 32'h200);
        check("drain_redir_pc", at(push_log, 0), 32'h200);

        // Misaligned redirect target.
        acc_log.delete();
        step(1'b1, 32'h0000_0102);
        repeat (12) step(1'b0, '0);
        check("mis_addr", at(acc_log, 0), ALIGN ? 32'h100 : 32'h102);

        // Address wrap at the top of the space.
        acc_log.delete();
        lat_min = 1; lat_max = 2;
        step(1'b1, 32'hFFFF_FFF8);
        repeat (10) step(1'b0, '0);
        check("wrap_addr2", at(acc_log, 2), 32'h0);

        // Long random runs, with a reset in between.
        p_rdy = 70; p_dec = 60; p_redir = 6; lat_min = 1; lat_max = 4;
        repeat (2000) step(1'b0, '0);
        do_reset();
        p_rdy = 50; p_dec = 80; p_redir = 4;
        repeat (2000) step(1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries; power of two, >=2.
REQ-003 SHALL have parameter MAX_OUTST, default 2, maximum in-flight memory reads; range 1..DEPTH.
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- redirect  in  1  branch/jump taken; flush queue and restart fetch.
- redirect_pc  in  XLEN  new fetch address, sampled when redirect=1.
- mem_rdy  in  1  memory accepts the current request.
- mem_valid  in  1  read data returned, in request order.
- mem_rdata  in  XLEN  returned instruction.
- proc_req  out  1  read request.
- we  out  1  write enable, constant 0.
- addr_out  out  XLEN  request address.
- dec_ready  in  1  decode consumes the head instruction.
- instr_valid  out  1  head entry present.
- instr_out  out  XLEN  head instruction.
- pc_out  out  XLEN  address of head instruction.
- freeze  out  1  equals !instr_valid.
- misalign  out  1  redirect target misaligned (see Configuration).

Function
REQ-006 SHALL accept a request in any cycle where proc_req=1 and mem_rdy=1; fetch_pc then increments by 4, modulo 2^XLEN.
REQ-007 SHALL hold addr_out and proc_req stable while proc_req=1 and mem_rdy=0.
REQ-008 SHALL drive addr_out = fetch_pc and assert proc_req only in state FETCH, when outstanding < MAX_OUTST, (count + outstanding) < DEPTH, and redirect=0.
REQ-009 SHALL push {mem_rdata, matching request PC} into the queue on each mem_valid in state FETCH; instr_valid rises the cycle after mem_valid (1-cycle latency).
REQ-010 SHALL pop the head when instr_valid=1 and dec_ready=1; simultaneous push and pop SHALL keep count unchanged.
REQ-011 SHALL drive instr_out = 32'h0000_0013 (NOP) and pc_out = 0 when the queue is empty.
REQ-012 SHALL ignore mem_valid when outstanding = 0.
REQ-013 SHALL, on redirect: empty the queue in the same edge, load fetch_pc <= redirect_pc, set discard count = outstanding minus any response arriving that cycle, and enter DRAIN if the discard count > 0, otherwise stay in FETCH.
REQ-014 SHALL, in DRAIN, deassert proc_req (unless a request is already held per REQ-007), drop every mem_valid and decrement discard; return to FETCH when discard reaches 0.
REQ-015 SHALL treat a redirect in DRAIN as a new redirect: update fetch_pc and recompute the discard count from outstanding.
REQ-016 SHALL track outstanding as +1 on accept and -1 on mem_valid; both in one cycle leaves it unchanged.

Reset
REQ-017 SHALL on rst=0 set state FETCH, fetch_pc=RESET_PC, count=outstanding=discard=0, proc_req=0, instr_valid=0, freeze=1, misalign=0, we=0, instr_out=NOP, pc_out=0.
REQ-018 SHALL drop all in-flight responses after reset deassertion; memory is reset with the block.

Configuration
REQ-019 SHALL, with macro IFQ_ALIGN_CHECK_EN defined, register misalign=1 for one cycle when redirect=1 and redirect_pc[1:0]!=0, and force redirect_pc[1:0] to 0 before loading fetch_pc.
REQ-020 SHALL, without IFQ_ALIGN_CHECK_EN, tie misalign to 0 and load redirect_pc unmodified.

Structure
REQ-021 SHALL place the state enum {FETCH, DRAIN}, the NOP constant, and the default XLEN in package ifq_pkg.
REQ-022 SHALL implement storage in sub-module ifq_fifo (parametrised width/depth; push, pop, flush, count, full, empty).

Verification
REQ-023 Reset, then mem_rdy=1, each response 2 cycles later -> addr_out sequence 0,4,8; instr_valid one cycle after each mem_valid; pc_out matches.
REQ-024 dec_ready=0, DEPTH=4 -> at most 4 requests accepted; proc_req=0 while count+outstanding=4; one pop re-enables proc_req.
REQ-025 mem_rdy=0 for 3 cycles with proc_req=1 -> addr_out stable; freeze=1 while the queue is empty.
REQ-026 Redirect to 0x100 with 2 outstanding -> queue empty next cycle; next 2 mem_valid dropped; next request addr_out=0x100.
REQ-027 Redirect during DRAIN to 0x200 -> discard recomputed; first enqueued pc_out=0x200.
REQ-028 With IFQ_ALIGN_CHECK_EN, redirect_pc=0x102 -> misalign pulses for 1 cycle; next addr_out=0x100.
